// File: rtl/spi_reg_write_arbiter.sv
// Round-robin arbiter that turns on-chip register-write requests into 16-bit
// MSB-first SPI write frames, rejecting out-of-range addresses locally.
module spi_reg_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_MAX = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_err,
  output logic                 cs_n,
  output logic                 copi,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        frame_q, frame_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               copi_q, copi_d;
  logic               done_q, done_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic [6:0]         gnt_addr;
  logic [7:0]         gnt_data;
  logic               addr_legal;

  // Walk the search order backwards so the last hit is the first requester after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        gnt_addr = req_addr[7*i +: 7];
        gnt_data = req_data[8*i +: 8];
      end
    end
    addr_legal = (int'(gnt_addr) <= ADDR_MAX);
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_n_d    = cs_n_q;
    copi_d    = copi_q;
    ready_d   = '0;
    err_d     = '0;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          rr_ptr_d = gnt_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
              ready_d[i] = 1'b1;
              err_d[i]   = !addr_legal;
            end
          end
          if (addr_legal) begin
            frame_d   = {1'b1, gnt_addr, gnt_data};
            cs_n_d    = 1'b0;
            copi_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == 4'd15) begin
          cs_n_d    = 1'b1;
          copi_d    = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          // frame_q[15] is already on the wire; bit 14 of the shifted word is next.
          bit_cnt_d = bit_cnt_q + 4'd1;
          copi_d    = frame_q[14];
          frame_d   = {frame_q[14:0], 1'b0};
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'(IDLE_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge sclk) begin
    frame_q <= frame_d;
  end

  assign req_ready  = ready_q;
  assign req_err    = err_q;
  assign cs_n       = cs_n_q;
  assign copi       = copi_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_write_arbiter.sv
// Self-checking bench for spi_reg_write_arbiter: a negedge monitor collects
// frames off cs_n/copi and scenario tasks compare them against queued expectations.
module tb_spi_reg_write_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int ADDR_MAX = 4;
  localparam int IDLE_GAP = 2;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [13:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready, req_err;
  logic        cs_n, copi, busy, frame_done;

  int checks = 0;
  int failures = 0;
  int exp_rr = NUM_REQ - 1;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          len_q[$];
  logic        end_done_q[$];
  int          gap_q[$];
  int          done_cnt = 0;

  logic [15:0] cur;
  int          cur_len = 0;
  int          hi_run = 0;
  bit          in_frame = 1'b0;
  bit          seen_end = 1'b0;

  always #5 sclk = ~sclk;

  spi_reg_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_MAX(ADDR_MAX),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_err   (req_err),
    .cs_n      (cs_n),
    .copi      (copi),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Frame monitor: assembles bits while cs_n is low, records cs_n-high run before each frame.
  initial begin
    cur = '0;
    forever begin
      @(negedge sclk);
      if (rst_n !== 1'b1) begin
        in_frame = 1'b0;
        seen_end = 1'b0;
        hi_run   = 0;
      end else begin
        if (frame_done === 1'b1) done_cnt++;
        if (cs_n === 1'b0) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            cur      = '0;
            cur_len  = 0;
            if (seen_end) gap_q.push_back(hi_run);
          end
          cur = {cur[14:0], copi};
          cur_len++;
        end else begin
          if (in_frame) begin
            in_frame = 1'b0;
            obs_q.push_back(cur);
            len_q.push_back(cur_len);
            end_done_q.push_back(frame_done);
            seen_end = 1'b1;
            hi_run   = 0;
          end
          hi_run++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [6:0] a, input logic [7:0] d);
    req_valid[i]       = v;
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge sclk);
      if (req_ready !== 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = (obs_q.size() >= n);
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge sclk);
      ok = (obs_q.size() >= n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    checks++; if (copi !== 1'b0) begin failures++; $display("FAIL reset_copi got=%b exp=0", copi); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (req_err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", req_err); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n  = 1'b1;
    exp_rr = NUM_REQ - 1;
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_single_write();
    bit ok;
    int n0, busy_len, gl;
    logic [15:0] e, g;
    logic gd;
    n0 = done_cnt;
    @(posedge sclk); #1;
    set_req(0, 1'b1, 7'h02, 8'hA5);
    exp_q.push_back(16'h82A5);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_ready_timeout got=none exp=pulse");
    end else begin
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
      checks++; if (req_err !== 2'b00) begin failures++; $display("FAIL single_err got=%b exp=00", req_err); end
      busy_len = (busy === 1'b1) ? 1 : 0;
      @(posedge sclk); #1;
      req_valid[0] = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge sclk);
        if (busy !== 1'b1) break;
        busy_len++;
      end
      checks++; if (busy_len != 16 + IDLE_GAP) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_len, 16 + IDLE_GAP); end
    end
    exp_rr = 0;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_frame_timeout got=none exp=frame");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); gl = len_q.pop_front(); gd = end_done_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL single_frame got=%h exp=%h", g, e); end
      checks++; if (gl != 16) begin failures++; $display("FAIL single_cs_len got=%0d exp=16", gl); end
      checks++; if (gd !== 1'b1) begin failures++; $display("FAIL single_frame_done got=%b exp=1", gd); end
    end
    checks++; if (done_cnt - n0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - n0); end
  endtask

  task automatic test_contention();
    bit ok;
    int first, ng, eidx, gi, gl;
    int rounds[2];
    logic [6:0] addr_of[2];
    logic [7:0] base_of[2];
    logic [15:0] e, g;
    addr_of = '{7'h01, 7'h03};
    base_of = '{8'h10, 8'h20};
    rounds  = '{0, 0};
    first   = (exp_rr + 1) % NUM_REQ;
    gap_q.delete();
    for (int k = 0; k < 4; k++) begin
      eidx = (first + k) % NUM_REQ;
      exp_q.push_back({1'b1, addr_of[eidx], base_of[eidx] + 8'(k / 2)});
    end
    @(posedge sclk); #1;
    set_req(0, 1'b1, addr_of[0], base_of[0]);
    set_req(1, 1'b1, addr_of[1], base_of[1]);
    ng = 0;
    for (int n = 0; n < 400 && ng < 4; n++) begin
      @(negedge sclk);
      if (req_ready !== 2'b00) begin
        eidx = (first + ng) % NUM_REQ;
        checks++; if (req_ready !== (2'b01 << eidx)) begin failures++; $display("FAIL cont_grant%0d got=%b exp=%b", ng, req_ready, 2'b01 << eidx); end
        gi = req_ready[1] ? 1 : 0;
        rounds[gi]++;
        ng++;
        @(posedge sclk); #1;
        if (rounds[gi] < 2) set_req(gi, 1'b1, addr_of[gi], base_of[gi] + 8'(rounds[gi]));
        else req_valid[gi] = 1'b0;
      end
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL cont_grant_count got=%0d exp=4", ng); end
    exp_rr = (first + 3) % NUM_REQ;
    wait_frames(4, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL cont_frame_timeout got=%0d exp=4", obs_q.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        e = exp_q.pop_front(); g = obs_q.pop_front(); gl = len_q.pop_front(); void'(end_done_q.pop_front());
        checks++; if (g !== e) begin failures++; $display("FAIL cont_frame%0d got=%h exp=%h", f, g, e); end
        checks++; if (gl != 16) begin failures++; $display("FAIL cont_cs_len%0d got=%0d exp=16", f, gl); end
      end
    end
    checks++;
    if (gap_q.size() < 4) begin
      failures++; $display("FAIL cont_gap_count got=%0d exp=4", gap_q.size());
    end else begin
      for (int k = gap_q.size() - 3; k < gap_q.size(); k++) begin
        checks++; if (gap_q[k] != IDLE_GAP + 1) begin failures++; $display("FAIL cont_gap%0d got=%0d exp=%0d", k, gap_q[k], IDLE_GAP + 1); end
      end
    end
  endtask

  task automatic test_illegal_addr();
    bit ok;
    int n0, lat, gl;
    logic [15:0] e, g;
    n0 = done_cnt;
    @(posedge sclk); #1;
    set_req(1, 1'b1, 7'h05, 8'h33);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL illegal_ready_timeout got=none exp=pulse");
    end else begin
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL illegal_ready got=%b exp=10", req_ready); end
      checks++; if (req_err !== 2'b10) begin failures++; $display("FAIL illegal_err got=%b exp=10", req_err); end
      checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL illegal_cs_n got=%b exp=1", cs_n); end
      @(posedge sclk); #1;
      set_req(1, 1'b1, 7'h03, 8'h5C);
      exp_q.push_back(16'h835C);
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge sclk);
        if (cs_n === 1'b0) begin lat = k; break; end
      end
      checks++; if (lat != IDLE_GAP + 1) begin failures++; $display("FAIL illegal_next_latency got=%0d exp=%0d", lat, IDLE_GAP + 1); end
      checks++; if (req_ready !== 2'b10 || req_err !== 2'b00) begin failures++; $display("FAIL illegal_next_grant got=%b/%b exp=10/00", req_ready, req_err); end
      checks++; if (done_cnt != n0) begin failures++; $display("FAIL illegal_no_done got=%0d exp=%0d", done_cnt, n0); end
      @(posedge sclk); #1;
      req_valid[1] = 1'b0;
    end
    exp_rr = 1;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL illegal_frame_timeout got=none exp=frame");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); gl = len_q.pop_front(); void'(end_done_q.pop_front());
      checks++; if (g !== e) begin failures++; $display("FAIL illegal_next_frame got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_boundary_addr();
    bit ok;
    logic [15:0] e, g;
    int gl;
    logic gd;
    @(posedge sclk); #1;
    set_req(0, 1'b1, 7'h04, 8'hFF);
    exp_q.push_back(16'h84FF);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL boundary_ready_timeout got=none exp=pulse");
    end else begin
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL boundary_ready got=%b exp=01", req_ready); end
      checks++; if (req_err !== 2'b00) begin failures++; $display("FAIL boundary_err got=%b exp=00", req_err); end
      @(posedge sclk); #1;
      req_valid[0] = 1'b0;
    end
    exp_rr = 0;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL boundary_frame_timeout got=none exp=frame");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); gl = len_q.pop_front(); gd = end_done_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL boundary_frame got=%h exp=%h", g, e); end
      checks++; if (gd !== 1'b1) begin failures++; $display("FAIL boundary_frame_done got=%b exp=1", gd); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n0, gl;
    logic [15:0] e, g;
    @(posedge sclk); #1;
    set_req(0, 1'b1, 7'h01, 8'hBC);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rstmid_ready_timeout got=none exp=pulse");
    end else begin
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_ready got=%b exp=01", req_ready); end
      @(posedge sclk); #1;
      set_req(0, 1'b1, 7'h00, 8'h77);
      set_req(1, 1'b1, 7'h02, 8'h22);
      repeat (8) @(negedge sclk);
      checks++; if (cs_n !== 1'b0 || copi !== 1'b1) begin failures++; $display("FAIL rstmid_bit8 got=%b%b exp=01", cs_n, copi); end
      n0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); end
      checks++; if (copi !== 1'b0) begin failures++; $display("FAIL rstmid_copi got=%b exp=0", copi); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      repeat (3) @(negedge sclk);
      rst_n  = 1'b1;
      exp_rr = NUM_REQ - 1;
      exp_q.push_back(16'h8077);
      exp_q.push_back(16'h8222);
      wait_ready(ok);
      checks++; if (!ok || req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_first_grant got=%b exp=01", req_ready); end
      checks++; if (done_cnt != n0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, n0); end
      @(posedge sclk); #1;
      req_valid[0] = 1'b0;
      wait_ready(ok);
      checks++; if (!ok || req_ready !== 2'b10) begin failures++; $display("FAIL rstmid_second_grant got=%b exp=10", req_ready); end
      @(posedge sclk); #1;
      req_valid[1] = 1'b0;
      exp_rr = 1;
      wait_frames(2, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rstmid_frame_timeout got=%0d exp=2", obs_q.size());
      end else begin
        for (int f = 0; f < 2; f++) begin
          e = exp_q.pop_front(); g = obs_q.pop_front(); gl = len_q.pop_front(); void'(end_done_q.pop_front());
          checks++; if (g !== e) begin failures++; $display("FAIL rstmid_frame%0d got=%h exp=%h", f, g, e); end
          checks++; if (gl != 16) begin failures++; $display("FAIL rstmid_cs_len%0d got=%0d exp=16", f, gl); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_illegal_addr();
    test_boundary_addr();
    test_reset_mid_frame();
    repeat (30) @(negedge sclk);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL leftover_frames got=%0d exp=0", obs_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
